spi_xfer_ctrl: RTL and testbench
================================

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 The block SHALL have parameter XFER_CYCLES, default 16: mclk cycles from the start pulse until the SPI shift completes. Legal range 1..255.
REQ-002 The block SHALL have port mclk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 The block SHALL have ports req_valid (input, 1) and req_ready (output, 1): the transfer-request handshake.
REQ-005 The block SHALL have ports req_mdata and req_sdata, input, 8 each: the bytes to load into the master and into the slave.
REQ-006 The block SHALL have ports rsp_valid (output, 1) and rsp_ready (input, 1): the response handshake.
REQ-007 The block SHALL have ports rsp_mdata and rsp_sdata, output, 8 each: the bytes read back from the master and from the slave.
REQ-008 The block SHALL have outputs load_master, load_slave, start, read_master and read_slave, 1 bit each: strobes to the SPI pair.
REQ-009 The block SHALL have outputs data_in_master and data_in_slave (8 each), and inputs data_out_master and data_out_slave (8 each), connected to the SPI pair.
REQ-010 The block SHALL have output busy, 1: high in every state except IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, LOAD, START, WAIT, READ, CAPT and RESP.
REQ-012 In IDLE, req_ready SHALL be 1 and req_ready SHALL be 0 in every other state. The edge with req_valid and req_ready both high SHALL latch req_mdata and req_sdata and move the FSM to LOAD.
REQ-013 In LOAD, load_master and load_slave SHALL be 1 for exactly one cycle, then the FSM SHALL move to START.
REQ-014 data_in_master and data_in_slave SHALL drive the latched bytes continuously from LOAD until the next accept.
REQ-015 In START, start SHALL be 1 for one cycle and the cycle counter SHALL load XFER_CYCLES-1, then the FSM SHALL move to WAIT.
REQ-016 In WAIT, the counter SHALL decrement each cycle; when the counter equals 0 the FSM SHALL move to READ, so WAIT lasts exactly XFER_CYCLES cycles.
REQ-017 In READ, read_master and read_slave SHALL be 1 for one cycle, then the FSM SHALL move to CAPT.
REQ-018 In CAPT, rsp_mdata SHALL take data_out_master and rsp_sdata SHALL take data_out_slave, then the FSM SHALL move to RESP.
REQ-019 In RESP, rsp_valid SHALL be 1 and the rsp data SHALL be held stable until rsp_ready is high; on that edge the FSM SHALL move to IDLE.
REQ-020 Latency from the accept edge to the first rsp_valid cycle SHALL be XFER_CYCLES+5 cycles when no back-pressure is applied.
REQ-021 At most one strobe SHALL be high in any cycle.
REQ-022 req_valid while busy SHALL be ignored, with no loss of the in-flight transfer.
REQ-023 If rsp_ready is already high on entry to RESP, the FSM SHALL return to IDLE after one cycle, and a new request SHALL be accepted no earlier than the following cycle.

Reset
REQ-024 Asserting reset SHALL immediately force the FSM to IDLE, set all strobes, rsp_valid and busy to 0, set req_ready to 1 on release, and clear the counter, data_in_* and rsp_* to 0.
REQ-025 A reset during any state SHALL abort the transfer, and no response SHALL be produced for it.

Configuration
REQ-026 With SPI_XFER_STATS_EN defined, the block SHALL add output xfer_cnt (16): it increments on each rsp handshake, wraps from 0xFFFF to 0x0000, and resets to 0.
REQ-027 Without SPI_XFER_STATS_EN, the xfer_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Package spi_ctrl_pkg SHALL hold the state enum typedef, the default XFER_CYCLES constant, and the 8-bit data typedef.
REQ-029 The cycle counter SHALL be sub-module spi_xfer_timer (inputs load and value, output zero), sized $clog2(XFER_CYCLES+1).

Verification
REQ-030 Test: XFER_CYCLES=16, req 0xA5/0x3C, with the SPI model swapping bytes -> rsp_mdata=0x3C and rsp_sdata=0xA5, with rsp_valid at cycle 21 after accept.
REQ-031 Test: hold rsp_ready low for 10 cycles -> rsp_valid and the data stay stable, busy=1, and req_ready=0 throughout.
REQ-032 Test: pulse req_valid during WAIT -> no second load, exactly one response, and that request is accepted only once back in IDLE.
REQ-033 Test: assert reset mid-WAIT -> strobes at 0 in the same cycle, then IDLE with no rsp_valid; a following transfer completes normally.
REQ-034 Test: XFER_CYCLES=1, back-to-back requests with rsp_ready tied high -> one start pulse per request and a strobe order of load, start, read every time.
REQ-035 Test: with SPI_XFER_STATS_EN defined, preload 0xFFFE and run 3 transfers -> xfer_cnt reads 0xFFFF, 0x0000, 0x0001.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI transfer controller.
package spi_ctrl_pkg;

  localparam int unsigned XFER_CYCLES_DEF = 16;
  localparam int unsigned DATA_W          = 8;

  typedef logic [DATA_W-1:0] data_t;

  // Master/slave byte pair carried through one transfer.
  typedef struct packed {
    data_t mdata;
    data_t sdata;
  } xfer_data_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_READ  = 3'd4,
    ST_CAPT  = 3'd5,
    ST_RESP  = 3'd6
  } state_e;

endpackage

// File: rtl/spi_xfer_timer.sv
// Down-counter timing the SPI shift; zero is registered alongside the count.
module spi_xfer_timer #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q;

  // Load takes priority; otherwise count down and stick at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register and its zero flag.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero = zero_q;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Sequences one SPI master/slave exchange per request handshake.
// Optional build macro: SPI_XFER_STATS_EN adds the xfer_cnt handshake counter.
module spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned XFER_CYCLES = XFER_CYCLES_DEF
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_mdata,
  input  logic [7:0]  req_sdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_mdata,
  output logic [7:0]  rsp_sdata,
  output logic        load_master,
  output logic        load_slave,
  output logic        start,
  output logic        read_master,
  output logic        read_slave,
  output logic [7:0]  data_in_master,
  output logic [7:0]  data_in_slave,
  input  logic [7:0]  data_out_master,
  input  logic [7:0]  data_out_slave,
  output logic        busy
`ifdef SPI_XFER_STATS_EN
  ,
  output logic [15:0] xfer_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(XFER_CYCLES + 1);

  state_e     state_q, state_d;
  xfer_data_t req_q, rsp_q;
  logic       req_ready_q, busy_q, load_q, start_q, read_q, rsp_valid_q;
  logic       accept, timer_load, timer_zero;

  assign accept     = (state_q == ST_IDLE) && req_valid;
  assign timer_load = (state_q == ST_START);

  spi_xfer_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .mclk  (mclk),
    .reset (reset),
    .load  (timer_load),
    .value (CNT_W'(XFER_CYCLES - 1)),
    .zero  (timer_zero)
  );

  // Next-state logic for the transfer sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (timer_zero) state_d = ST_READ;
      ST_READ:  state_d = ST_CAPT;
      ST_CAPT:  state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs decoded from the next state so they line up with the state register.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      load_q      <= 1'b0;
      start_q     <= 1'b0;
      read_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      req_ready_q <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
      load_q      <= (state_d == ST_LOAD);
      start_q     <= (state_d == ST_START);
      read_q      <= (state_d == ST_READ);
      rsp_valid_q <= (state_d == ST_RESP);
    end
  end

  // Latch request bytes on accept and response bytes in CAPT.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      req_q <= '0;
      rsp_q <= '0;
    end else begin
      if (accept) begin
        req_q <= '{mdata: req_mdata, sdata: req_sdata};
      end
      if (state_q == ST_CAPT) begin
        rsp_q <= '{mdata: data_out_master, sdata: data_out_slave};
      end
    end
  end

`ifdef SPI_XFER_STATS_EN
  logic [15:0] xfer_cnt_q;

  // Completed-response counter, wraps naturally.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      xfer_cnt_q <= '0;
    end else if ((state_q == ST_RESP) && rsp_ready) begin
      xfer_cnt_q <= xfer_cnt_q + 16'd1;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

  assign req_ready      = req_ready_q;
  assign busy           = busy_q;
  assign load_master    = load_q;
  assign load_slave     = load_q;
  assign start          = start_q;
  assign read_master    = read_q;
  assign read_slave     = read_q;
  assign rsp_valid      = rsp_valid_q;
  assign data_in_master = req_q.mdata;
  assign data_in_slave  = req_q.sdata;
  assign rsp_mdata      = rsp_q.mdata;
  assign rsp_sdata      = rsp_q.sdata;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: XFER_CYCLES=16 instance plus an XFER_CYCLES=1 instance.
module tb_spi_xfer_ctrl;

  logic mclk, reset;

  // XFER_CYCLES = 16 instance
  logic       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0] req_mdata, req_sdata, rsp_mdata, rsp_sdata;
  logic       load_master, load_slave, start, read_master, read_slave, busy;
  logic [7:0] data_in_master, data_in_slave, data_out_master, data_out_slave;
`ifdef SPI_XFER_STATS_EN
  logic [15:0] xfer_cnt, xfer_cnt_b;
`endif

  // XFER_CYCLES = 1 instance
  logic       req_valid_b, req_ready_b, rsp_valid_b, rsp_ready_b;
  logic [7:0] req_mdata_b, req_sdata_b, rsp_mdata_b, rsp_sdata_b;
  logic       load_master_b, load_slave_b, start_b, read_master_b, read_slave_b, busy_b;
  logic [7:0] data_in_master_b, data_in_slave_b;

  int n_tests = 0;
  int n_fail  = 0;
  int loads_n = 0, starts_n = 0, reads_n = 0, resps_n = 0, ord0 = 0;
  int loads_b = 0, starts_b = 0, reads_b = 0, resps_b = 0, ord1 = 0;

  logic [7:0] m_reg, s_reg;

  spi_xfer_ctrl #(.XFER_CYCLES(16)) u_dut (
    .mclk(mclk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mdata(req_mdata), .req_sdata(req_sdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_mdata(rsp_mdata), .rsp_sdata(rsp_sdata),
    .load_master(load_master), .load_slave(load_slave), .start(start),
    .read_master(read_master), .read_slave(read_slave),
    .data_in_master(data_in_master), .data_in_slave(data_in_slave),
    .data_out_master(data_out_master), .data_out_slave(data_out_slave),
    .busy(busy)
`ifdef SPI_XFER_STATS_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  spi_xfer_ctrl #(.XFER_CYCLES(1)) u_dut1 (
    .mclk(mclk), .reset(reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_mdata(req_mdata_b), .req_sdata(req_sdata_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_mdata(rsp_mdata_b), .rsp_sdata(rsp_sdata_b),
    .load_master(load_master_b), .load_slave(load_slave_b), .start(start_b),
    .read_master(read_master_b), .read_slave(read_slave_b),
    .data_in_master(data_in_master_b), .data_in_slave(data_in_slave_b),
    .data_out_master(data_in_slave_b), .data_out_slave(data_in_master_b),
    .busy(busy_b)
`ifdef SPI_XFER_STATS_EN
    , .xfer_cnt(xfer_cnt_b)
`endif
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // SPI pair model: bytes load on the load strobes and swap on start.
  always @(posedge mclk or posedge reset) begin
    if (reset) begin
      m_reg <= 8'h00;
      s_reg <= 8'h00;
    end else if (load_master && load_slave) begin
      m_reg <= data_in_master;
      s_reg <= data_in_slave;
    end else if (start) begin
      m_reg <= s_reg;
      s_reg <= m_reg;
    end
  end
  assign data_out_master = m_reg;
  assign data_out_slave  = s_reg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge mclk);
    #1;
  endtask

  // Strobe exclusivity and load -> start -> read ordering, instance 16.
  always @(negedge mclk) begin
    if (reset) begin
      ord0 = 0;
    end else begin
      if (load_master | load_slave | start | read_master | read_slave) begin
        check("strobe_excl", 32'(int'(load_master) + int'(start) + int'(read_master)), 32'd1);
        check("load_pair", 32'(load_slave), 32'(load_master));
        check("read_pair", 32'(read_slave), 32'(read_master));
        if (load_master) begin
          check("order_load", 32'(ord0 == 0 || ord0 == 3), 32'd1);
          ord0 = 1; loads_n++;
        end
        if (start) begin
          check("order_start", 32'(ord0), 32'd1);
          ord0 = 2; starts_n++;
        end
        if (read_master) begin
          check("order_read", 32'(ord0), 32'd2);
          ord0 = 3; reads_n++;
        end
      end
      if (rsp_valid && rsp_ready) resps_n++;
    end
  end

  // Same monitor for the XFER_CYCLES=1 instance.
  always @(negedge mclk) begin
    if (reset) begin
      ord1 = 0;
    end else begin
      if (load_master_b | load_slave_b | start_b | read_master_b | read_slave_b) begin
        check("b_strobe_excl", 32'(int'(load_master_b) + int'(start_b) + int'(read_master_b)), 32'd1);
        check("b_load_pair", 32'(load_slave_b), 32'(load_master_b));
        check("b_read_pair", 32'(read_slave_b), 32'(read_master_b));
        if (load_master_b) begin
          check("b_order_load", 32'(ord1 == 0 || ord1 == 3), 32'd1);
          ord1 = 1; loads_b++;
        end
        if (start_b) begin
          check("b_order_start", 32'(ord1), 32'd1);
          ord1 = 2; starts_b++;
        end
        if (read_master_b) begin
          check("b_order_read", 32'(ord1), 32'd2);
          ord1 = 3; reads_b++;
        end
      end
      if (rsp_valid_b && rsp_ready_b) resps_b++;
    end
  end

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  // One full transfer on the 16-cycle instance with no back-pressure.
  task automatic run_xfer(input logic [7:0] m, input logic [7:0] s);
    int n;
    req_mdata = m;
    req_sdata = s;
    req_valid = 1'b1;
    check("xfer_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    wait_rsp(n);
    check("xfer_latency", 32'(n + 1), 32'd21);
    check("xfer_rsp_mdata", 32'(rsp_mdata), 32'(s));
    check("xfer_rsp_sdata", 32'(rsp_sdata), 32'(m));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int c, n, lc, sc, rc, l0, r0, vcnt;
    logic [7:0] bm [3];
    logic [7:0] bs [3];
    bm[0] = 8'h12; bm[1] = 8'h9C; bm[2] = 8'hF0;
    bs[0] = 8'h34; bs[1] = 8'h47; bs[2] = 8'h0F;

    reset = 1'b1;
    req_valid = 1'b0; req_mdata = 8'h00; req_sdata = 8'h00; rsp_ready = 1'b0;
    req_valid_b = 1'b0; req_mdata_b = 8'h00; req_sdata_b = 8'h00; rsp_ready_b = 1'b0;

    // Reset state
    step(); step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobes", 32'({load_master, load_slave, start, read_master, read_slave}), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_data_in", 32'({data_in_master, data_in_slave}), 32'd0);
    check("rst_rsp_data", 32'({rsp_mdata, rsp_sdata}), 32'd0);
`ifdef SPI_XFER_STATS_EN
    check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
`endif
    reset = 1'b0;
    step();
    check("rel_req_ready", 32'(req_ready), 32'd1);
    check("rel_busy", 32'(busy), 32'd0);

    // Basic transfer A5/3C with latency and strobe timing, then back-pressure hold
    req_mdata = 8'hA5; req_sdata = 8'h3C; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    c = 1; lc = 0; sc = 0; rc = 0;
    while (rsp_valid !== 1'b1 && c < 60) begin
      if (load_master) lc = c;
      if (start) sc = c;
      if (read_master) rc = c;
      step();
      c++;
    end
    check("lat_rsp_valid", 32'(c), 32'd21);
    check("lat_load", 32'(lc), 32'd1);
    check("lat_start", 32'(sc), 32'd2);
    check("lat_read", 32'(rc), 32'd19);
    check("din_master", 32'(data_in_master), 32'hA5);
    check("din_slave", 32'(data_in_slave), 32'h3C);
    check("rsp_mdata", 32'(rsp_mdata), 32'h3C);
    check("rsp_sdata", 32'(rsp_sdata), 32'hA5);
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", 32'({rsp_mdata, rsp_sdata}), 32'h3CA5);
      check("hold_busy", 32'(busy), 32'd1);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("done_valid", 32'(rsp_valid), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
    check("done_req_ready", 32'(req_ready), 32'd1);
    check("done_resps", 32'(resps_n), 32'd1);

    // req_valid while busy is ignored until back in IDLE
    l0 = loads_n; r0 = resps_n;
    req_mdata = 8'h11; req_sdata = 8'h22; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (4) step();
    req_mdata = 8'h77; req_sdata = 8'h88; req_valid = 1'b1;
    rsp_ready = 1'b1;
    wait_rsp(n);
    check("busy_req_lat", 32'(n), 32'd16);
    check("busy_req_loads", 32'(loads_n - l0), 32'd1);
    check("busy_req_din", 32'(data_in_master), 32'h11);
    check("busy_req_rsp", 32'({rsp_mdata, rsp_sdata}), 32'h2211);
    step();
    check("busy_req_idle", 32'(req_ready), 32'd1);
    check("busy_req_din_hold", 32'(data_in_master), 32'h11);
    step();
    req_valid = 1'b0;
    check("busy_req_accept", 32'({data_in_master, data_in_slave}), 32'h7788);
    check("busy_req_busy", 32'(busy), 32'd1);
    wait_rsp(n);
    check("busy_req_lat2", 32'(n), 32'd20);
    check("busy_req_rsp2", 32'({rsp_mdata, rsp_sdata}), 32'h8877);
    step();
    rsp_ready = 1'b0;
    check("busy_req_loads2", 32'(loads_n - l0), 32'd2);
    check("busy_req_resps", 32'(resps_n - r0), 32'd2);

    // Reset in the middle of WAIT aborts the transfer
    req_mdata = 8'h5A; req_sdata = 8'hC3; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (4) step();
    check("midwait_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_strobes", 32'({load_master, load_slave, start, read_master, read_slave}), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_din", 32'({data_in_master, data_in_slave}), 32'd0);
    step();
    reset = 1'b0;
    step();
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    vcnt = 0;
    repeat (30) begin
      step();
      if (rsp_valid) vcnt++;
    end
    check("midrst_no_rsp", 32'(vcnt), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);
    run_xfer(8'h12, 8'h34);

`ifdef SPI_XFER_STATS_EN
    // Handshake counter wrap from a preloaded value
    force u_dut.xfer_cnt_q = 16'hFFFE;
    step();
    release u_dut.xfer_cnt_q;
    check("cnt_preload", 32'(xfer_cnt), 32'hFFFE);
    run_xfer(8'h01, 8'h02);
    check("cnt_ffff", 32'(xfer_cnt), 32'hFFFF);
    run_xfer(8'h03, 8'h04);
    check("cnt_wrap", 32'(xfer_cnt), 32'h0000);
    run_xfer(8'h05, 8'h06);
    check("cnt_one", 32'(xfer_cnt), 32'h0001);
`endif

    // XFER_CYCLES=1 back-to-back with rsp_ready tied high
    rsp_ready_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_mdata_b = bm[k];
      req_sdata_b = bs[k];
      req_valid_b = 1'b1;
      if (k > 0) begin
        step();
        check("b2b_idle_gap", 32'(busy_b), 32'd0);
      end
      step();
      n = 1;
      while (rsp_valid_b !== 1'b1 && n < 50) begin
        step();
        n++;
      end
      check("b2b_latency", 32'(n), 32'd6);
      check("b2b_rsp", 32'({rsp_mdata_b, rsp_sdata_b}), 32'({bs[k], bm[k]}));
    end
    req_valid_b = 1'b0;
    step(); step();
    check("b2b_starts", 32'(starts_b), 32'd3);
    check("b2b_loads", 32'(loads_b), 32'd3);
    check("b2b_reads", 32'(reads_b), 32'd3);
    check("b2b_resps", 32'(resps_b), 32'd3);
    check("b2b_idle_end", 32'(busy_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
